// File: rtl/cache_pkg.sv
// Shared types and constants for the cache arbiter.
// Holds the FSM state encoding, bus widths and default timing.
package cache_pkg;

   localparam int ADDR_W = 8;
   localparam int DATA_W = 8;
   localparam int STAT_W = 8;
   localparam int CNT_W  = 4;

   localparam int HIT_CYCLES_DEF  = 2;
   localparam int MISS_CYCLES_DEF = 8;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      MISS   = 2'd2,
      RESP   = 2'd3
   } state_t;

   // Statistics counters stick at all-ones instead of wrapping.
   function automatic logic [STAT_W-1:0] sat_inc(
      input logic [STAT_W-1:0] v
   );
      return (v == '1) ? v : v + STAT_W'(1);
   endfunction

endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin pick: lone request wins, ties go to the
// requester not granted last. Ports: req0/req1, last_grant -> grant, valid.
module rr_pick2 (
   input  logic req0,
   input  logic req1,
   input  logic last_grant,
   output logic grant,
   output logic valid
);

   assign valid = req0 | req1;
   assign grant = (req0 & req1) ? ~last_grant : req1;

endmodule

// File: rtl/cache_arbiter.sv
// Arbitrates fetch (0) and data (1) requesters onto one cache port.
// Ports: clk/clr, req/rw/addr/wdata per requester, ack pulses, rdata,
// cache_* bus, cache_hit/cache_data_out, busy, hit_cnt/miss_cnt.
module cache_arbiter
   import cache_pkg::*;
#(
   parameter int HIT_CYCLES  = HIT_CYCLES_DEF,
   parameter int MISS_CYCLES = MISS_CYCLES_DEF
) (
   input  logic              clk,
   input  logic              clr,
   input  logic              req0,
   input  logic              req1,
   input  logic              rw0,
   input  logic              rw1,
   input  logic [ADDR_W-1:0] addr0_in,
   input  logic [ADDR_W-1:0] addr1_in,
   input  logic [DATA_W-1:0] wdata0,
   input  logic [DATA_W-1:0] wdata1,
   output logic              ack0,
   output logic              ack1,
   output logic [DATA_W-1:0] rdata,
   output logic              cache_enab,
   output logic              cache_rw,
   output logic [ADDR_W-1:0] cache_addr,
   output logic [DATA_W-1:0] cache_data,
   input  logic [DATA_W-1:0] cache_data_out,
   input  logic              cache_hit,
   output logic              busy,
   output logic [STAT_W-1:0] hit_cnt,
   output logic [STAT_W-1:0] miss_cnt
);

   localparam logic [CNT_W-1:0] HIT_LD  = CNT_W'(HIT_CYCLES - 1);
   localparam logic [CNT_W-1:0] MISS_LD = CNT_W'(MISS_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   state_t              r_state;
   logic [CNT_W-1:0]    r_cnt;
   logic                r_last;
   logic                r_rw;
   logic [ADDR_W-1:0]   r_addr;
   logic [DATA_W-1:0]   r_wdata;
   logic [DATA_W-1:0]   r_rdata;
   logic [STAT_W-1:0]   r_hit_cnt;
   logic [STAT_W-1:0]   r_miss_cnt;

   state_t              w_next_state;
   logic [CNT_W-1:0]    w_next_cnt;
   logic                w_gnt;
   logic                w_valid;
   logic                w_grant_en;
   logic                w_capture;
   logic                w_hit_inc;
   logic                w_miss_inc;

   rr_pick2 u_pick (
      .req0       (req0),
      .req1       (req1),
      .last_grant (r_last),
      .grant      (w_gnt),
      .valid      (w_valid)
   );

   always_comb begin
      w_next_state = r_state;
      w_next_cnt   = r_cnt;
      w_grant_en   = 1'b0;
      w_capture    = 1'b0;
      w_hit_inc    = 1'b0;
      w_miss_inc   = 1'b0;
      unique case (r_state)
         IDLE: begin
            if (w_valid) begin
               w_grant_en   = 1'b1;
               w_next_cnt   = HIT_LD;
               w_next_state = ACCESS;
            end
         end
         ACCESS: begin
            if (r_cnt == '0) begin
               if (cache_hit) begin
                  w_capture    = 1'b1;
                  w_hit_inc    = 1'b1;
                  w_next_state = RESP;
               end else begin
                  w_miss_inc   = 1'b1;
                  w_next_cnt   = MISS_LD;
                  w_next_state = MISS;
               end
            end else begin
               w_next_cnt = r_cnt - CNT_ONE;
            end
         end
         MISS: begin
            if (r_cnt == '0) begin
               w_capture    = 1'b1;
               w_next_state = RESP;
            end else begin
               w_next_cnt = r_cnt - CNT_ONE;
            end
         end
         RESP: begin
            w_next_state = IDLE;
         end
         default: begin
            w_next_state = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         r_state    <= IDLE;
         r_cnt      <= '0;
         r_last     <= 1'b1;
         r_rw       <= 1'b0;
         r_addr     <= '0;
         r_wdata    <= '0;
         r_rdata    <= '0;
         r_hit_cnt  <= '0;
         r_miss_cnt <= '0;
      end else begin
         r_state <= w_next_state;
         r_cnt   <= w_next_cnt;
         // r_last doubles as the index of the in-flight requester.
         if (w_grant_en) begin
            r_last  <= w_gnt;
            r_rw    <= w_gnt ? rw1 : rw0;
            r_addr  <= w_gnt ? addr1_in : addr0_in;
            r_wdata <= w_gnt ? wdata1 : wdata0;
         end
         if (w_capture && !r_rw) begin
            r_rdata <= cache_data_out;
         end
         if (w_hit_inc) begin
            r_hit_cnt <= sat_inc(r_hit_cnt);
         end
         if (w_miss_inc) begin
            r_miss_cnt <= sat_inc(r_miss_cnt);
         end
      end
   end

   assign busy       = (r_state != IDLE);
   assign cache_enab = (r_state == ACCESS) || (r_state == MISS);
   assign cache_rw   = r_rw;
   assign cache_addr = r_addr;
   assign cache_data = r_wdata;
   assign ack0       = (r_state == RESP) && !r_last;
   assign ack1       = (r_state == RESP) && r_last;
   assign rdata      = r_rdata;
   assign hit_cnt    = r_hit_cnt;
   assign miss_cnt   = r_miss_cnt;

endmodule

// File: tb/tb_cache_arbiter.sv
// Self-checking bench for cache_arbiter with a transaction-level model.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_cache_arbiter;

   localparam int HIT  = 2;
   localparam int MISS = 8;

   logic       clk = 1'b0;
   logic       clr = 1'b0;
   logic       req0 = 1'b0;
   logic       req1 = 1'b0;
   logic       rw0 = 1'b0;
   logic       rw1 = 1'b0;
   logic [7:0] addr0_in = '0;
   logic [7:0] addr1_in = '0;
   logic [7:0] wdata0 = '0;
   logic [7:0] wdata1 = '0;
   logic       ack0;
   logic       ack1;
   logic [7:0] rdata;
   logic       cache_enab;
   logic       cache_rw;
   logic [7:0] cache_addr;
   logic [7:0] cache_data;
   logic [7:0] cache_data_out = '0;
   logic       cache_hit = 1'b0;
   logic       busy;
   logic [7:0] hit_cnt;
   logic [7:0] miss_cnt;

   int checks = 0;
   int failures = 0;

   // Model: who was granted last, statistics, last read data.
   int         m_last;
   int         m_hit;
   int         m_miss;
   logic [7:0] m_rdata;
   int         grant_log[$];

   always #5 clk = ~clk;

   cache_arbiter #(
      .HIT_CYCLES  (HIT),
      .MISS_CYCLES (MISS)
   ) dut (
      .clk            (clk),
      .clr            (clr),
      .req0           (req0),
      .req1           (req1),
      .rw0            (rw0),
      .rw1            (rw1),
      .addr0_in       (addr0_in),
      .addr1_in       (addr1_in),
      .wdata0         (wdata0),
      .wdata1         (wdata1),
      .ack0           (ack0),
      .ack1           (ack1),
      .rdata          (rdata),
      .cache_enab     (cache_enab),
      .cache_rw       (cache_rw),
      .cache_addr     (cache_addr),
      .cache_data     (cache_data),
      .cache_data_out (cache_data_out),
      .cache_hit      (cache_hit),
      .busy           (busy),
      .hit_cnt        (hit_cnt),
      .miss_cnt       (miss_cnt)
   );

   task automatic model_reset();
      m_last  = 1;
      m_hit   = 0;
      m_miss  = 0;
      m_rdata = '0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      clr  = 1'b0;
      req0 = 1'b0;
      req1 = 1'b0;
      repeat (2) @(negedge clk);
      clr = 1'b1;
      model_reset();
   endtask

   // Runs one round of requests to completion and checks every ack.
   task automatic serve(
      input logic       r0,
      input logic       r1,
      input logic       w0,
      input logic       w1,
      input logic [7:0] a0,
      input logic [7:0] a1,
      input logic [7:0] d0,
      input logic [7:0] d1,
      input logic       hitv,
      input logic [7:0] dout,
      input int         drop_c
   );
      int         order[2];
      int         n;
      int         g;
      int         lat;
      int         c;
      int         en_cnt;
      bit         seen;
      bit         bad_bus;
      bit         bad_busy;
      logic       rwv[2];
      logic [7:0] av[2];
      logic [7:0] dv[2];
      logic [1:0] exp_ack;
      rwv[0] = w0; rwv[1] = w1;
      av[0] = a0;  av[1] = a1;
      dv[0] = d0;  dv[1] = d1;
      @(negedge clk);
      checks++;
      if (busy !== 1'b0) begin
         failures++;
         $display("FAIL idle_before: busy=%0b want 0", busy);
      end
      cache_hit      = hitv;
      cache_data_out = dout;
      rw0 = w0; addr0_in = a0; wdata0 = d0;
      rw1 = w1; addr1_in = a1; wdata1 = d1;
      req0 = r0;
      req1 = r1;
      if (r0 && r1) begin
         order[0] = (m_last == 1) ? 0 : 1;
         order[1] = 1 - order[0];
         n = 2;
      end else begin
         order[0] = r1 ? 1 : 0;
         order[1] = 0;
         n = 1;
      end
      lat = hitv ? HIT + 1 : HIT + MISS + 1;
      for (int k = 0; k < n; k++) begin
         g = order[k];
         c = 0;
         en_cnt = 0;
         seen = 0;
         bad_bus = 0;
         bad_busy = 0;
         while (!seen && c < lat + 4) begin
            @(negedge clk);
            c++;
            if (ack0 || ack1) begin
               seen = 1;
            end else begin
               if (busy !== 1'b1) bad_busy = 1;
               if (cache_enab === 1'b1) begin
                  en_cnt++;
                  if (cache_addr !== av[g] || cache_data !== dv[g] ||
                      cache_rw !== rwv[g])
                     bad_bus = 1;
               end
               if (k == 0 && drop_c == c) begin
                  if (g == 0) req0 = 1'b0;
                  else req1 = 1'b0;
               end
            end
         end
         checks++;
         if (!seen) begin
            failures++;
            $display("FAIL ack_timeout: no ack, want ack%0d at %0d", g, lat);
         end else begin
            grant_log.push_back(ack1 ? 1 : 0);
            m_last = g;
            if (hitv) begin
               if (m_hit < 255) m_hit++;
            end else begin
               if (m_miss < 255) m_miss++;
            end
            if (!rwv[g]) m_rdata = dout;
            exp_ack = (g == 1) ? 2'b01 : 2'b10;
            checks++;
            if ({ack0, ack1} !== exp_ack) begin
               failures++;
               $display("FAIL ack_who: ack0/1=%b want %b", {ack0, ack1}, exp_ack);
            end
            checks++;
            if (c != lat) begin
               failures++;
               $display("FAIL latency: cycle=%0d want %0d", c, lat);
            end
            checks++;
            if (en_cnt != lat - 1) begin
               failures++;
               $display("FAIL enab_len: %0d want %0d", en_cnt, lat - 1);
            end
            checks++;
            if (bad_bus || bad_busy) begin
               failures++;
               $display("FAIL bus_hold: bus=%0b busy=%0b want 0 0", bad_bus, bad_busy);
            end
            checks++;
            if (rdata !== m_rdata) begin
               failures++;
               $display("FAIL rdata: %h want %h", rdata, m_rdata);
            end
            checks++;
            if (hit_cnt !== 8'(m_hit) || miss_cnt !== 8'(m_miss)) begin
               failures++;
               $display("FAIL stats: hit=%0d miss=%0d want %0d %0d",
                        hit_cnt, miss_cnt, m_hit, m_miss);
            end
         end
         if (g == 0) req0 = 1'b0;
         else req1 = 1'b0;
         @(negedge clk);
         checks++;
         if ({ack0, ack1, busy} !== 3'b000) begin
            failures++;
            $display("FAIL gap_idle: ack0/ack1/busy=%b want 000", {ack0, ack1, busy});
         end
      end
   endtask

   task automatic test_reset();
      repeat (2) @(negedge clk);
      checks++;
      if ({ack0, ack1, busy, cache_enab, cache_rw} !== 5'b0) begin
         failures++;
         $display("FAIL reset_ctrl: %b want 00000",
                  {ack0, ack1, busy, cache_enab, cache_rw});
      end
      checks++;
      if ({cache_addr, cache_data, rdata} !== 24'h0) begin
         failures++;
         $display("FAIL reset_bus: %h want 0", {cache_addr, cache_data, rdata});
      end
      checks++;
      if ({hit_cnt, miss_cnt} !== 16'h0) begin
         failures++;
         $display("FAIL reset_stats: %h want 0", {hit_cnt, miss_cnt});
      end
      clr = 1'b1;
      model_reset();
   endtask

   task automatic test_read_hit();
      serve(1, 0, 0, 0, 8'h01, 8'h00, 8'h00, 8'h00, 1, 8'hE0, 0);
      checks++;
      if (rdata !== 8'hE0 || hit_cnt !== 8'd1) begin
         failures++;
         $display("FAIL read_hit: rdata=%h hit=%0d want E0 1", rdata, hit_cnt);
      end
   endtask

   task automatic test_write_miss();
      serve(0, 1, 0, 1, 8'h00, 8'h04, 8'h00, 8'h18, 0, 8'h5A, 0);
      checks++;
      if (rdata !== 8'hE0 || miss_cnt !== 8'd1) begin
         failures++;
         $display("FAIL write_miss: rdata=%h miss=%0d want E0 1", rdata, miss_cnt);
      end
   endtask

   task automatic test_tie();
      do_reset();
      grant_log.delete();
      serve(1, 1, 0, 0, 8'h10, 8'h20, 8'h00, 8'h00, 1, 8'h11, 0);
      serve(1, 1, 0, 1, 8'h30, 8'h40, 8'h00, 8'h77, 1, 8'h22, 0);
      checks++;
      if (grant_log.size() != 4 || grant_log[0] != 0 || grant_log[1] != 1 ||
          grant_log[2] != 0 || grant_log[3] != 1) begin
         failures++;
         $display("FAIL tie_order: got %p want 0 1 0 1", grant_log);
      end
   endtask

   task automatic test_drop_req();
      serve(1, 0, 0, 0, 8'h55, 8'h00, 8'h00, 8'h00, 1, 8'h9C, 1);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         checks++;
         if ({ack0, ack1, busy} !== 3'b000) begin
            failures++;
            $display("FAIL drop_after: %b want 000", {ack0, ack1, busy});
         end
      end
   endtask

   task automatic test_reset_mid_miss();
      bit stray;
      do_reset();
      cache_hit = 1'b0;
      rw1 = 1'b1; addr1_in = 8'h33; wdata1 = 8'h44;
      req1 = 1'b1;
      repeat (6) @(negedge clk);
      checks++;
      if (cache_enab !== 1'b1 || busy !== 1'b1) begin
         failures++;
         $display("FAIL mid_active: enab=%0b busy=%0b want 1 1", cache_enab, busy);
      end
      clr = 1'b0;
      #1;
      checks++;
      if ({ack0, ack1, busy, cache_enab, cache_rw, cache_addr, cache_data,
           rdata, hit_cnt, miss_cnt} !== 45'h0) begin
         failures++;
         $display("FAIL mid_clr: outputs nonzero want all 0");
      end
      req1 = 1'b0;
      @(negedge clk);
      clr = 1'b1;
      model_reset();
      stray = 0;
      repeat (12) begin
         @(negedge clk);
         if (ack0 || ack1 || busy) stray = 1;
      end
      checks++;
      if (stray) begin
         failures++;
         $display("FAIL mid_noack: stray ack/busy=1 want 0");
      end
      serve(0, 1, 0, 0, 8'h00, 8'h66, 8'h00, 8'h00, 1, 8'hC3, 0);
   endtask

   task automatic test_random();
      int pat;
      for (int i = 0; i < 60; i++) begin
         pat = $urandom_range(0, 2);
         serve(pat != 1, pat != 0,
               1'($urandom), 1'($urandom),
               8'($urandom), 8'($urandom),
               8'($urandom), 8'($urandom),
               1'($urandom), 8'($urandom),
               $urandom_range(0, 3));
      end
   endtask

   task automatic test_saturate();
      do_reset();
      for (int i = 0; i < 300; i++)
         serve(1, 0, 0, 0, 8'($urandom), 8'h00, 8'h00, 8'h00, 1, 8'($urandom), 0);
      checks++;
      if (hit_cnt !== 8'd255 || miss_cnt !== 8'd0) begin
         failures++;
         $display("FAIL saturate: hit=%0d miss=%0d want 255 0", hit_cnt, miss_cnt);
      end
   endtask

   initial begin
      test_reset();
      test_read_hit();
      test_write_miss();
      test_tie();
      test_drop_req();
      test_reset_mid_miss();
      test_random();
      test_saturate();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
